// File: rtl/valid_ready_downsizer.sv
// rtl/valid_ready_downsizer.sv - wide-to-narrow valid/ready stream width converter
module valid_ready_downsizer #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [OUT_WIDTH*RATIO-1:0]   in_data,
    input  logic [$clog2(RATIO)-1:0]     in_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
);
    localparam int IN_WIDTH = OUT_WIDTH * RATIO;
    localparam int CW       = $clog2(RATIO);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [IN_WIDTH-1:0]             r_hold;
    logic [CW-1:0]                   r_idx;
    logic [CW-1:0]                   r_len;
    logic [RATIO-1:0][OUT_WIDTH-1:0] w_slices;
    logic [CW-1:0]                   w_sel;
    logic                            w_at_last;
    logic                            w_in_xfer;
    logic                            w_out_xfer;

    assign w_at_last  = (r_idx == r_len);
    assign out_valid  = (r_state == SEND);
    assign out_last   = out_valid && w_at_last;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Reloading on the final beat's out_ready keeps the output stream gap-free.
    assign in_ready = !rst && ((r_state == IDLE) || (out_ready && w_at_last));

    assign w_slices = r_hold;

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_sel = r_idx;
        end else begin : g_msb_first
            assign w_sel = CW'(RATIO - 1) - r_idx;
        end
    endgenerate

    assign out_data = w_slices[w_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_in_xfer) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (w_out_xfer && w_at_last && !w_in_xfer) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_len  <= '0;
            r_idx  <= '0;
        end else if (w_in_xfer) begin
            r_hold <= in_data;
            r_len  <= in_len;
            r_idx  <= '0;
        end else if (w_out_xfer && !w_at_last) begin
            r_idx  <= r_idx + 1'b1;
        end
    end

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

    // Once the last beat leaves without a reload, no further beat of that word may follow.
    a_single_last: assert property (@(posedge clk) disable iff (rst)
        (w_out_xfer && out_last && !w_in_xfer) |=> !out_valid);

endmodule

// File: tb/tb_valid_ready_downsizer.sv
// tb/tb_valid_ready_downsizer.sv - scoreboard bench for valid_ready_downsizer in both slice orders
module tb_valid_ready_downsizer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  in_len;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_m;
    logic [7:0]  out_data;
    logic [7:0]  out_data_m;
    logic        out_valid;
    logic        out_valid_m;
    logic        out_ready;
    logic        out_last;
    logic        out_last_m;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_l[$];
    logic [8:0] exp_m[$];

    always #5 clk = ~clk;

    valid_ready_downsizer #(.OUT_WIDTH(8), .RATIO(4), .LSB_FIRST(1)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_len(in_len), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    valid_ready_downsizer #(.OUT_WIDTH(8), .RATIO(4), .LSB_FIRST(0)) dut_m (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_len(in_len), .in_valid(in_valid), .in_ready(in_ready_m),
        .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready), .out_last(out_last_m)
    );

    function automatic logic [7:0] slice_of(logic [31:0] d, int k);
        return d[k*8 +: 8];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(logic [31:0] d, int len);
        for (int b = 0; b <= len; b++) begin
            exp_l.push_back({(b == len), slice_of(d, b)});
            exp_m.push_back({(b == len), slice_of(d, 3 - b)});
        end
    endtask

    // Presents a word and returns at posedge+1 right after it has been accepted.
    task automatic accept(logic [31:0] d, logic [1:0] len);
        bit ok = 0;
        in_data  = d;
        in_len   = len;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: got in_ready=0 expected in_ready=1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_l.size() == 0) begin
                check("lsb_unexpected_beat", {23'd0, out_last, out_data}, 32'hFFFF_FFFF);
            end else begin
                check("lsb_beat", {23'd0, out_last, out_data}, {23'd0, exp_l.pop_front()});
            end
        end
        if (!rst && out_valid_m && out_ready) begin
            if (exp_m.size() == 0) begin
                check("msb_unexpected_beat", {23'd0, out_last_m, out_data_m}, 32'hFFFF_FFFF);
            end else begin
                check("msb_beat", {23'd0, out_last_m, out_data_m}, {23'd0, exp_m.pop_front()});
            end
        end
    end

    logic pat[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int done;
        rst       = 1'b1;
        in_data   = '0;
        in_len    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_data", out_data, 0);
        check("reset_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full word, continuous out_ready
        push_word(32'hDDCCBBAA, 3);
        accept(32'hDDCCBBAA, 2'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("full_out_valid", out_valid, 1);
            check("full_in_ready", in_ready, (k == 3));
            check("full_out_last", out_last, (k == 3));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("full_idle_after", out_valid, 0);
        @(posedge clk);
        #1;

        // Short word
        push_word(32'h44332211, 1);
        accept(32'h44332211, 2'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("short_out_valid", out_valid, 1);
            check("short_out_last", out_last, (k == 1));
            check("short_in_ready", in_ready, (k == 1));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("short_idle_after", out_valid, 0);
        @(posedge clk);
        #1;

        // Back-to-back words with in_valid held
        push_word(32'h03020100, 3);
        push_word(32'h07060504, 3);
        in_data  = 32'h03020100;
        in_len   = 2'd3;
        in_valid = 1'b1;
        @(negedge clk);
        check("b2b_first_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_data = 32'h07060504;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_no_gap", out_valid, 1);
            if (i <= 3) check("b2b_in_ready", in_ready, (i == 3));
            @(posedge clk);
            #1;
            if (i == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_idle_after", out_valid, 0);
        @(posedge clk);
        #1;

        // Backpressure
        push_word(32'hDDCCBBAA, 3);
        accept(32'hDDCCBBAA, 2'd3);
        done = 0;
        for (int i = 0; i < 10; i++) begin
            out_ready = pat[i];
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, slice_of(32'hDDCCBBAA, done));
            check("bp_out_last", out_last, (done == 3));
            check("bp_in_ready", in_ready, (pat[i] && done == 3));
            if (pat[i]) done++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_after", out_valid, 0);
        @(posedge clk);
        #1;

        // Single-beat word: LSB instance gives AA, MSB instance gives DD
        push_word(32'hDDCCBBAA, 0);
        accept(32'hDDCCBBAA, 2'd0);
        @(negedge clk);
        check("len0_msb_data", out_data_m, 32'hDD);
        check("len0_msb_last", out_last_m, 1);
        check("len0_lsb_data", out_data, 32'hAA);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("len0_idle_after", out_valid_m, 0);
        @(posedge clk);
        #1;

        // Reset mid-word after the second beat
        for (int b = 0; b < 2; b++) begin
            exp_l.push_back({1'b0, slice_of(32'hDDCCBBAA, b)});
            exp_m.push_back({1'b0, slice_of(32'hDDCCBBAA, 3 - b)});
        end
        accept(32'hDDCCBBAA, 2'd3);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_out_valid_m", out_valid_m, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_last", out_last, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        push_word(32'h000000EE, 0);
        accept(32'h000000EE, 2'd0);
        @(negedge clk);
        check("post_rst_data", out_data, 32'hEE);
        check("post_rst_last", out_last, 1);
        @(posedge clk);
        #1;

        repeat (3) @(posedge clk);
        #1;
        check("lsb_queue_drained", exp_l.size(), 0);
        check("msb_queue_drained", exp_m.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/valid_ready_downsizer.md
Name: valid_ready_downsizer

Overview:
- Stream width converter between two valid/ready channels. Accepts one wide word of OUT_WIDTH*RATIO bits on its input and emits it as 1..RATIO narrow beats on its output.
- Sits directly upstream of any consumer that uses the standard valid/ready interface at OUT_WIDTH. Typically it is fed by a wide datapath stage.
- The output is registered; the input handshake allows zero-bubble back-to-back words.

Parameters:
- OUT_WIDTH, 8: width of the output data beat in bits.
- RATIO, 4: narrow beats per wide input word; must be >= 2.
- LSB_FIRST, 1: 1 sends bits [OUT_WIDTH-1:0] first; 0 sends the most-significant slice first.
- Derived (localparam): IN_WIDTH = OUT_WIDTH*RATIO; CW = $clog2(RATIO).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  IN_WIDTH  wide word.
- in_len  input  CW  number of valid beats minus 1 (0 = 1 beat, RATIO-1 = full word); sampled with in_data.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  OUT_WIDTH  current narrow beat.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts beat.
- out_last  output  1  high on the final beat of each word.

Behaviour:
- Internal state:
  - Holding register hold[IN_WIDTH-1:0].
  - Beat index idx[CW-1:0] and captured length len[CW-1:0].
  - FSM with states IDLE (no word held) and SEND (word held, out_valid=1).
- Reset (async assert, sync release):
  - State IDLE; out_valid=0; out_last=0; out_data=0; idx=0; len=0; hold=0.
  - in_ready=0 while rst is high.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Input readiness (combinational): in_ready = !rst && (state==IDLE || (out_ready && idx==len)).
  - in_ready depends combinationally on out_ready; this path is permitted and documented.
- IDLE:
  - On an input transfer: capture hold<=in_data, len<=in_len, idx<=0, go to SEND.
  - out_valid rises the next cycle. Latency from input transfer to first beat valid is 1 cycle.
- SEND:
  - out_valid=1.
  - out_data = slice idx of hold when LSB_FIRST=1, else slice (RATIO-1-idx). Slice k = hold[k*OUT_WIDTH +: OUT_WIDTH].
  - out_last = (idx==len).
- Output transfer with idx<len: idx<=idx+1.
- Output transfer with idx==len (end of word):
  - If an input transfer occurs in the same cycle: reload hold/len, idx<=0, stay in SEND. No bubble.
  - Otherwise go to IDLE; out_valid=0 the next cycle.
- out_valid && !out_ready: out_data, out_last and idx hold stable; out_valid never deasserts without a transfer.
- Slices above len are never emitted; their contents are ignored.
- in_len is ignored unless an input transfer occurs.
- Throughput:
  - Word with len=L occupies L+1 output cycles under continuous out_ready.
  - Sustained output is 1 beat/cycle across word boundaries.
- Reset asserted mid-word: the word is discarded immediately and the block returns to the reset values above. No partial beat is emitted after reset release.
- Assertions:
  - out_valid && !out_ready ⇒ out_data, out_last stable next cycle.
  - At most one out_last per accepted word.

Test Plan:
- Full word, LSB_FIRST=1, out_ready=1: in_data=32'hDDCCBBAA, in_len=3 → out_data AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after accept. out_last only on DD. in_ready low for cycles 1–3 and high on the DD cycle.
- Short word: in_data=32'h44332211, in_len=1 → beats 11,22, out_last on 22. Bytes 33/44 are never emitted. Block returns to IDLE (out_valid=0) the following cycle.
- Back-to-back: words 32'h03020100 then 32'h07060504, both in_len=3, in_valid held, out_ready=1 → 8 contiguous beats 00..07 with no out_valid gap. The second word is accepted on the cycle beat 03 transfers.
- Backpressure: out_ready toggles 1,0,0,1,… during a full word → out_data/out_last held during stalls. All 4 beats delivered once, in order. in_ready stays 0 until the last beat's out_ready cycle.
- MSB_FIRST (LSB_FIRST=0), in_data=32'hDDCCBBAA, in_len=3 → beats DD,CC,BB,AA. With in_len=0 → single beat DD with out_last=1.
- Reset mid-word: assert rst after beat BB of 32'hDDCCBBAA → out_valid=0 asynchronously, in_ready=0 during reset. After release: no CC/DD emitted, in_ready=1. A new word 32'h000000EE, in_len=0 is accepted and emitted as EE with out_last=1.
